// File: rtl/uart_baud_pkg.sv
// Shared constants and elaboration helpers for the fractional UART baud generator.
package uart_baud_pkg;

    localparam int DEF_CNT_WIDTH  = 13;
    localparam int DEF_FRAC_BITS  = 3;
    localparam int DEF_OVERSAMPLE = 16;

    function automatic int tick_index_width(input int oversample);
        return $clog2(oversample);
    endfunction

    // The phase counter relies on natural binary wrap, so only powers of two are legal.
    function automatic bit oversample_legal(input int oversample);
        return (oversample == 4) || (oversample == 8) || (oversample == 16);
    endfunction

endpackage

// File: rtl/uart_frac_baud_gen_if.sv
// Control/status bundle between the UART core (master) and the baud generator (slave).
interface uart_frac_baud_gen_if
    import uart_baud_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) ();

    localparam int IDX_WIDTH = tick_index_width(OVERSAMPLE);

    logic                 ENABLE;
    logic [CNT_WIDTH-1:0] BAUD_VAL;
    logic [FRAC_BITS-1:0] BAUD_VAL_FRACTION;
    logic                 BAUD_RELOAD;
    logic                 BAUD_TICK;
    logic                 XMIT_PULSE;
    logic [IDX_WIDTH-1:0] TICK_INDEX;

    modport master (
        output ENABLE, BAUD_VAL, BAUD_VAL_FRACTION, BAUD_RELOAD,
        input  BAUD_TICK, XMIT_PULSE, TICK_INDEX
    );

    modport slave (
        input  ENABLE, BAUD_VAL, BAUD_VAL_FRACTION, BAUD_RELOAD,
        output BAUD_TICK, XMIT_PULSE, TICK_INDEX
    );

endinterface

// File: rtl/uart_baud_frac_acc.sv
// First-order fraction accumulator: adds the numerator on every step and reports the
// wrap as a carry that stretches the current tick period by one cycle.
module uart_baud_frac_acc
    import uart_baud_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 clear,
    input  logic                 step,
    input  logic [FRAC_BITS-1:0] frac,
    output logic                 carry
);

    logic [FRAC_BITS-1:0] acc;
    logic [FRAC_BITS:0]   sum;

    // Carry is combinational so the counter reload in the same cycle can include it.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, frac};
    end

    assign carry = sum[FRAC_BITS];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[FRAC_BITS-1:0];
        end
    end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// Fractional baud-rate generator: oversample tick every BAUD_VAL+1(+carry) cycles and a
// bit pulse on every OVERSAMPLE-th tick, with enable, restart and tick-phase output.
module uart_frac_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit FRAC_EN    = 1'b1
) (
    input logic             CLK,
    input logic             RESET,
    uart_frac_baud_gen_if.slave bus
);

    localparam int                   IDX_WIDTH = tick_index_width(OVERSAMPLE);
    localparam logic [IDX_WIDTH-1:0] LAST_SUB  = IDX_WIDTH'(OVERSAMPLE - 1);
    localparam logic [IDX_WIDTH-1:0] SUB_ONE   = IDX_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   CNT_ONE   = (CNT_WIDTH + 1)'(1);

    if (!oversample_legal(OVERSAMPLE)) begin : g_bad_oversample
        $error("uart_frac_baud_gen: OVERSAMPLE must be 4, 8 or 16");
    end

    // One spare counter bit so BAUD_VAL all-ones plus a carry cannot wrap.
    logic [CNT_WIDTH:0]   cnt;
    logic [IDX_WIDTH-1:0] sub;
    logic                 tick_evt;
    logic                 carry;
    logic                 baud_tick_q;
    logic                 xmit_pulse_q;
    logic [IDX_WIDTH-1:0] tick_index_q;

    always_comb begin
        tick_evt = bus.ENABLE && (cnt == '0) && !bus.BAUD_RELOAD;
    end

    if (FRAC_EN) begin : g_frac
        uart_baud_frac_acc #(
            .FRAC_BITS(FRAC_BITS)
        ) u_frac_acc (
            .CLK   (CLK),
            .RESET (RESET),
            .clear (bus.BAUD_RELOAD),
            .step  (tick_evt),
            .frac  (bus.BAUD_VAL_FRACTION),
            .carry (carry)
        );
    end else begin : g_no_frac
        logic unused_frac;
        assign unused_frac = ^bus.BAUD_VAL_FRACTION;
        assign carry       = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt          <= '0;
            sub          <= '0;
            baud_tick_q  <= 1'b0;
            xmit_pulse_q <= 1'b0;
            tick_index_q <= '0;
        end else begin
            baud_tick_q  <= tick_evt;
            xmit_pulse_q <= tick_evt && (sub == LAST_SUB);
            tick_index_q <= tick_evt ? sub : '0;

            // Reload outranks enable; BAUD_VAL is only sampled here or on a tick.
            if (bus.BAUD_RELOAD) begin
                cnt <= {1'b0, bus.BAUD_VAL};
                sub <= '0;
            end else if (tick_evt) begin
                cnt <= {1'b0, bus.BAUD_VAL} + {{CNT_WIDTH{1'b0}}, carry};
                sub <= sub + SUB_ONE;
            end else if (bus.ENABLE && (cnt != '0)) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign bus.BAUD_TICK  = baud_tick_q;
    assign bus.XMIT_PULSE = xmit_pulse_q;
    assign bus.TICK_INDEX = tick_index_q;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Directed bench: a fractional 16x build (dut_a) and an integer-only 8x build (dut_b).
module tb_uart_frac_baud_gen;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    uart_frac_baud_gen_if #(.CNT_WIDTH(13), .FRAC_BITS(3), .OVERSAMPLE(16)) bus_a ();
    uart_frac_baud_gen_if #(.CNT_WIDTH(13), .FRAC_BITS(3), .OVERSAMPLE(8))  bus_b ();

    uart_frac_baud_gen #(
        .CNT_WIDTH(13), .FRAC_BITS(3), .OVERSAMPLE(16), .FRAC_EN(1'b1)
    ) dut_a (
        .CLK   (clk),
        .RESET (rst_a),
        .bus   (bus_a.slave)
    );

    uart_frac_baud_gen #(
        .CNT_WIDTH(13), .FRAC_BITS(3), .OVERSAMPLE(8), .FRAC_EN(1'b0)
    ) dut_b (
        .CLK   (clk),
        .RESET (rst_b),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [12:0] bv;
        logic [2:0]  frac;
        int          n;     // tick intervals measured after the first post-reload tick
        int          span;  // expected sum of those intervals
    } vec_t;

    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; dut_b's fraction input is
    // randomised every cycle since that build must ignore it.
    task automatic step();
        @(posedge clk);
        #1;
        bus_b.BAUD_VAL_FRACTION = 3'($urandom);
    endtask

    task automatic wait_tick(input bit sel, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((sel ? bus_b.BAUD_TICK : bus_a.BAUD_TICK) !== 1'b1) && (n < limit));
    endtask

    task automatic reload_a(input logic [12:0] bv, input logic [2:0] frac);
        bus_a.BAUD_VAL          = bv;
        bus_a.BAUD_VAL_FRACTION = frac;
        bus_a.BAUD_RELOAD       = 1'b1;
        step();
        bus_a.BAUD_RELOAD       = 1'b0;
    endtask

    initial begin
        int iv;
        int span;
        int t;
        int gap_ticks;
        int ticks;
        int xmits;
        int first_x;
        int last_x;

        vecs[0] = '{13'd3, 3'd4, 8, 36};
        vecs[1] = '{13'd3, 3'd1, 8, 33};
        vecs[2] = '{13'd3, 3'd0, 8, 32};
        vecs[3] = '{13'd5, 3'd7, 8, 55};
        vecs[4] = '{13'd2, 3'd3, 8, 27};
        vecs[5] = '{13'd0, 3'd4, 8, 12};
        vecs[6] = '{13'd0, 3'd0, 16, 16};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.ENABLE = 1'b1;  bus_a.BAUD_VAL = 13'd3; bus_a.BAUD_VAL_FRACTION = 3'd0; bus_a.BAUD_RELOAD = 1'b0;
        bus_b.ENABLE = 1'b1;  bus_b.BAUD_VAL = 13'd2; bus_b.BAUD_VAL_FRACTION = 3'd0; bus_b.BAUD_RELOAD = 1'b0;
        repeat (3) step();

        // Reset state and first tick after release.
        check("a_rst_tick", 32'(bus_a.BAUD_TICK), 0);
        check("a_rst_xmit", 32'(bus_a.XMIT_PULSE), 0);
        check("a_rst_idx",  32'(bus_a.TICK_INDEX), 0);
        rst_a = 1'b0;
        step();
        check("a_first_tick", 32'(bus_a.BAUD_TICK), 1);
        check("a_first_idx",  32'(bus_a.TICK_INDEX), 0);
        check("a_first_xmit", 32'(bus_a.XMIT_PULSE), 0);

        // BAUD_VAL=3, no fraction: 4-cycle ticks, bit pulse every 16 ticks.
        span = 0;
        for (int n = 1; n <= 31; n++) begin
            wait_tick(1'b0, 20, iv);
            check("t1_interval", 32'(iv), 4);
            check("t1_idx",  32'(bus_a.TICK_INDEX), 32'(n % 16));
            check("t1_xmit", 32'(bus_a.XMIT_PULSE), 32'((n % 16) == 15));
            if (n > 15) span += iv;
        end
        check("t1_xmit_span", 32'(span), 64);

        // Table: reload, first tick BV+1 later at phase 0, then summed interval spans.
        for (int v = 0; v < 7; v++) begin
            reload_a(vecs[v].bv, vecs[v].frac);
            check("tab_reload_quiet", 32'(bus_a.BAUD_TICK), 0);
            wait_tick(1'b0, 50, iv);
            check("tab_first_interval", 32'(iv), 32'(vecs[v].bv) + 1);
            check("tab_first_idx", 32'(bus_a.TICK_INDEX), 0);
            span = 0;
            for (int k = 0; k < vecs[v].n; k++) begin
                wait_tick(1'b0, 50, iv);
                span += iv;
            end
            check("tab_span", 32'(span), 32'(vecs[v].span));
        end

        // Reload exactly when a tick was due, mid-bit at phase 7.
        reload_a(13'd3, 3'd0);
        wait_tick(1'b0, 20, iv);
        for (int k = 1; k <= 7; k++) wait_tick(1'b0, 20, iv);
        check("rl_pre_idx", 32'(bus_a.TICK_INDEX), 7);
        repeat (3) step();
        reload_a(13'd3, 3'd0);
        check("rl_no_tick", 32'(bus_a.BAUD_TICK), 0);
        check("rl_no_xmit", 32'(bus_a.XMIT_PULSE), 0);
        wait_tick(1'b0, 20, iv);
        check("rl_interval", 32'(iv), 4);
        check("rl_idx0", 32'(bus_a.TICK_INDEX), 0);
        t = 0;
        do begin
            wait_tick(1'b0, 20, iv);
            t++;
        end while ((bus_a.XMIT_PULSE !== 1'b1) && (t < 20));
        check("rl_xmit_ticks", 32'(t), 15);
        check("rl_xmit_idx", 32'(bus_a.TICK_INDEX), 15);

        // ENABLE low for 10 cycles mid-period stretches that interval by 10.
        step();
        bus_a.ENABLE = 1'b0;
        gap_ticks = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            gap_ticks += int'(bus_a.BAUD_TICK);
        end
        check("gap_no_ticks", 32'(gap_ticks), 0);
        bus_a.ENABLE = 1'b1;
        wait_tick(1'b0, 30, iv);
        check("gap_interval", 32'(11 + iv), 14);
        check("gap_idx", 32'(bus_a.TICK_INDEX), 0);

        // BAUD_VAL changed without reload affects only the period after the next tick.
        reload_a(13'd3, 3'd0);
        wait_tick(1'b0, 20, iv);
        step();
        bus_a.BAUD_VAL = 13'd6;
        wait_tick(1'b0, 20, iv);
        check("bv_change_cur", 32'(1 + iv), 4);
        wait_tick(1'b0, 20, iv);
        check("bv_change_next", 32'(iv), 7);

        // Maximum divisor with a carry: 8193-cycle interval, no wrap.
        reload_a(13'h1FFF, 3'd4);
        wait_tick(1'b0, 9000, iv);
        check("max_first", 32'(iv), 8192);
        wait_tick(1'b0, 9000, iv);
        check("max_no_carry", 32'(iv), 8192);
        wait_tick(1'b0, 9000, iv);
        check("max_carry", 32'(iv), 8193);

        // BAUD_VAL=0: tick every cycle, bit pulse every 16 cycles.
        reload_a(13'd0, 3'd0);
        ticks = 0; xmits = 0; first_x = -1; last_x = -1;
        for (int i = 0; i < 48; i++) begin
            step();
            ticks += int'(bus_a.BAUD_TICK);
            if (bus_a.XMIT_PULSE === 1'b1) begin
                xmits++;
                if (first_x < 0) first_x = i;
                last_x = i;
            end
        end
        check("bv0_ticks", 32'(ticks), 48);
        check("bv0_xmits", 32'(xmits), 3);
        check("bv0_first_x", 32'(first_x), 15);
        check("bv0_last_x", 32'(last_x), 47);

        // Integer-only 8x build with a randomly toggling fraction input.
        check("b_rst_tick", 32'(bus_b.BAUD_TICK), 0);
        check("b_rst_xmit", 32'(bus_b.XMIT_PULSE), 0);
        check("b_rst_idx",  32'(bus_b.TICK_INDEX), 0);
        rst_b = 1'b0;
        step();
        check("b_first_tick", 32'(bus_b.BAUD_TICK), 1);
        check("b_first_idx",  32'(bus_b.TICK_INDEX), 0);
        for (int n = 1; n <= 22; n++) begin
            wait_tick(1'b1, 20, iv);
            check("b_interval", 32'(iv), 3);
            check("b_idx",  32'(bus_b.TICK_INDEX), 32'(n % 8));
            check("b_xmit", 32'(bus_b.XMIT_PULSE), 32'((n % 8) == 7));
        end

        // RESET when the phase-7 tick is due: outputs clear, then a fresh phase-0 tick.
        repeat (2) step();
        rst_b = 1'b1;
        step();
        check("b_mid_rst_tick", 32'(bus_b.BAUD_TICK), 0);
        check("b_mid_rst_xmit", 32'(bus_b.XMIT_PULSE), 0);
        check("b_mid_rst_idx",  32'(bus_b.TICK_INDEX), 0);
        rst_b = 1'b0;
        step();
        check("b_restart_tick", 32'(bus_b.BAUD_TICK), 1);
        check("b_restart_idx",  32'(bus_b.TICK_INDEX), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
